// File: rtl/periph_apb_bridge_if.sv
// ============================================================================
// Module  : periph_apb_bridge_if
// Brief   : Core-side request/response port plus APB4 bus of the bridge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface periph_apb_bridge_if #(
    parameter int APB_AW     = 32,
    parameter int APB_DW     = 32,
    parameter int SLAVES_QTY = 2
);
    localparam int PSTRB_W = APB_DW / 8;

    logic                         req_valid_i;
    logic                         req_ready_o;
    logic [APB_AW-1:0]            req_addr_i;
    logic                         req_write_i;
    logic [APB_DW-1:0]            req_wdata_i;
    logic [PSTRB_W-1:0]           req_strb_i;
    logic                         rsp_valid_o;
    logic                         rsp_ready_i;
    logic [APB_DW-1:0]            rsp_rdata_o;
    logic                         rsp_err_o;
    logic [SLAVES_QTY-1:0]        PSEL;
    logic                         PENABLE;
    logic                         PWRITE;
    logic [APB_AW-1:0]            PADDR;
    logic [APB_DW-1:0]            PWDATA;
    logic [PSTRB_W-1:0]           PSTRB;
    logic [SLAVES_QTY-1:0]        PREADY;
    logic [SLAVES_QTY*APB_DW-1:0] PRDATA;
    logic [SLAVES_QTY-1:0]        PSLVERR;

    // The bridge itself uses the slave view; the core and peripherals the master view.
    modport slave (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i,
        input  rsp_ready_i, PREADY, PRDATA, PSLVERR,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

    modport master (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i,
        output rsp_ready_i, PREADY, PRDATA, PSLVERR,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );
endinterface

`default_nettype wire

// File: rtl/periph_apb_bridge.sv
// ============================================================================
// Module  : periph_apb_bridge
// Brief   : Single-master APB4 bridge decoding timer and RTC windows.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module periph_apb_bridge #(
    parameter int                APB_AW         = 32,
    parameter int                APB_DW         = 32,
    parameter longint unsigned   PERIPH_BA      = 64'h0,
    parameter int                EF_TCC32_QTY   = 1,
    parameter int                RTC_QTY        = 1,
    parameter int                TIMEOUT_CYCLES = 256
) (
    input  wire logic              pclk,
    input  wire logic              prst_n,
    periph_apb_bridge_if.slave     bus
);
    localparam int PSTRB_W    = APB_DW / 8;
    localparam int SLAVES_QTY = EF_TCC32_QTY + RTC_QTY;
    localparam int IDX_W      = (SLAVES_QTY > 1) ? $clog2(SLAVES_QTY) : 1;
    localparam int CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    // One extra bit keeps window ends from wrapping at the top of the address space.
    typedef logic [APB_AW:0] ext_t;
    localparam ext_t c_tcc_size = ext_t'(4096);
    localparam ext_t c_rtc_size = ext_t'(64);
    localparam ext_t c_tcc_ba   = ext_t'(PERIPH_BA);
    localparam ext_t c_rtc_ba   = c_tcc_ba + ext_t'(EF_TCC32_QTY) * c_tcc_size;
    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_tmo_last = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [CNT_W-1:0]       r_cnt;
    logic [SLAVES_QTY-1:0]  r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [APB_AW-1:0]      r_paddr;
    logic [APB_DW-1:0]      r_pwdata;
    logic [PSTRB_W-1:0]     r_pstrb;
    logic                   r_rsp_valid;
    logic [APB_DW-1:0]      r_rsp_rdata;
    logic                   r_rsp_err;

    logic                   w_hit;
    logic                   w_ok;
    logic [IDX_W-1:0]       w_idx;
    logic [APB_AW-1:0]      w_off;
    ext_t                   w_addr;
    logic                   w_pready;
    logic                   w_pslverr;
    logic [APB_DW-1:0]      w_prdata;
    logic                   w_tmo;

    function automatic ext_t tcc_base(input int i);
        return c_tcc_ba + ext_t'(i) * c_tcc_size;
    endfunction

    function automatic ext_t rtc_base(input int i);
        return c_rtc_ba + ext_t'(i) * c_rtc_size;
    endfunction

    // Half-open window decode: base <= addr < base + size.
    always_comb begin
        w_hit  = 1'b0;
        w_idx  = '0;
        w_off  = '0;
        w_addr = ext_t'(bus.req_addr_i);
        for (int i = 0; i < EF_TCC32_QTY; i++) begin
            if (w_addr >= tcc_base(i) && w_addr < tcc_base(i + 1)) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(i);
                w_off = APB_AW'(w_addr - tcc_base(i));
            end
        end
        for (int j = 0; j < RTC_QTY; j++) begin
            if (w_addr >= rtc_base(j) && w_addr < rtc_base(j + 1)) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(EF_TCC32_QTY + j);
                w_off = APB_AW'(w_addr - rtc_base(j));
            end
        end
        w_ok = w_hit && (bus.req_addr_i[1:0] == 2'b00);
    end

    assign w_pready  = bus.PREADY[r_idx];
    assign w_pslverr = bus.PSLVERR[r_idx];
    assign w_prdata  = bus.PRDATA[r_idx*APB_DW +: APB_DW];
    assign w_tmo     = (TIMEOUT_CYCLES != 0) && (r_cnt >= c_tmo_last);

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        r_idx    <= w_idx;
                        r_paddr  <= w_off;
                        r_pwrite <= bus.req_write_i;
                        r_pwdata <= bus.req_wdata_i;
                        r_pstrb  <= bus.req_write_i ? bus.req_strb_i : '0;
                        if (w_ok) begin
                            r_psel  <= SLAVES_QTY'(1) << w_idx;
                            r_state <= S_SETUP;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_pready) begin
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_pslverr;
                        r_rsp_rdata <= (!r_pwrite && !w_pslverr) ? w_prdata : '0;
                        r_state     <= S_RESP;
                    end else if (w_tmo) begin
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= S_RESP;
                    end else if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = (r_state == S_IDLE);
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.PSEL        = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.PSTRB       = r_pstrb;

endmodule

`default_nettype wire
